// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_pkg
//  Description : Shared types and constants for the AXI4 memory responder:
//                burst encodings, response codes, snoop opcode, FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_mem_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY          = 2'b00;
  localparam logic [1:0] RESP_SLVERR        = 2'b10;
  localparam logic [3:0] SNOOP_MAKE_INVALID = 4'hD;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DATA  = 2'd1,
    W_SNOOP = 2'd2,
    W_RESP  = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // WRAP is only legal for 2, 4, 8 or 16 beats; anything else steps like INCR.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_addr
//  Description : Combinational next-beat address for 8-byte AXI beats.
//                FIXED holds, INCR/RSVD add 8, WRAP wraps inside a
//                (len+1)*8-byte aligned window.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_burst_addr
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_mask;

  assign w_incr = addr_i + ADDR_WIDTH'(8);
  // Window size minus one: (len+1)*8-1 == {len, 3'b111} for the legal wrap lengths.
  assign w_mask = ADDR_WIDTH'({len_i, 3'b111});

  // Select the stepping rule for the current burst type.
  always_comb begin
    next_addr_o = w_incr;
    case (burst_i)
      FIXED: next_addr_o = addr_i;
      WRAP: begin
        if (wrap_len_ok(len_i)) begin
          next_addr_o = (addr_i & ~w_mask) | (w_incr & w_mask);
        end
      end
      default: next_addr_o = w_incr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_responder
//  Description : AXI4 slave memory model with a word-addressed RAM. Serves
//                FIXED/INCR/WRAP bursts, one outstanding read and one
//                outstanding write. Optional MakeInvalid snoop on the AC
//                channel after each write burst, enabled by defining the
//                macro AXI_MEM_SNOOP_INV_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int ID_WIDTH     = 13,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2,
  localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // write address
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  // snoop
  output logic                  s_axi_acvalid,
  input  logic                  s_axi_acready,
  output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
  output logic [3:0]            s_axi_acsnoop
);

  localparam int                    c_idx_w     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-4:0] c_mem_words = (ADDR_WIDTH-3)'(MEM_WORDS);
  localparam logic [7:0]            c_rd_wait   = 8'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // --------------------------------------------------------------------------
  // Write path state
  // --------------------------------------------------------------------------
  wr_state_e             wr_state_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [7:0]            wlen_q;
  logic [1:0]            wburst_q;
  logic [7:0]            wcnt_q;
  logic                  werr_q;

  logic                  w_wbeat;
  logic                  w_woob;
  logic [c_idx_w-1:0]    w_widx;

`ifdef AXI_MEM_SNOOP_INV_EN
  logic                  acvalid_q;
  logic [ADDR_WIDTH-1:0] acaddr_q;
`endif

  // Reset aborts an in-flight burst, so a beat seen during reset never lands.
  assign w_wbeat = !reset && (wr_state_q == W_DATA) && s_axi_wvalid && wready_q;
  assign w_woob  = waddr_q[ADDR_WIDTH-1:3] >= c_mem_words;
  assign w_widx  = waddr_q[3 +: c_idx_w];

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_addr (
    .addr_i      (waddr_q),
    .len_i       (wlen_q),
    .burst_i     (wburst_q),
    .next_addr_o (waddr_d)
  );

  // Byte-strobed RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wbeat && !w_woob) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) begin
          mem_q[w_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM: accept AW, consume len+1 beats, optionally snoop, respond on B.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      waddr_q    <= '0;
      wlen_q     <= 8'd0;
      wburst_q   <= 2'b00;
      wcnt_q     <= 8'd0;
      werr_q     <= 1'b0;
`ifdef AXI_MEM_SNOOP_INV_EN
      acvalid_q  <= 1'b0;
      acaddr_q   <= '0;
`endif
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_axi_awvalid && awready_q) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            bid_q      <= s_axi_awid;
            waddr_q    <= s_axi_awaddr;
            wlen_q     <= s_axi_awlen;
            wburst_q   <= s_axi_awburst;
            wcnt_q     <= 8'd0;
            werr_q     <= (s_axi_awburst == RSVD);
`ifdef AXI_MEM_SNOOP_INV_EN
            acaddr_q   <= {s_axi_awaddr[ADDR_WIDTH-1:6], 6'b0};
`endif
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            waddr_q <= waddr_d;
            wcnt_q  <= wcnt_q + 8'd1;
            werr_q  <= werr_q | w_woob;
            if (wcnt_q == wlen_q) begin
              wready_q   <= 1'b0;
`ifdef AXI_MEM_SNOOP_INV_EN
              acvalid_q  <= 1'b1;
              wr_state_q <= W_SNOOP;
`else
              bvalid_q   <= 1'b1;
              bresp_q    <= (werr_q | w_woob) ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= W_RESP;
`endif
            end
          end
        end
`ifdef AXI_MEM_SNOOP_INV_EN
        W_SNOOP: begin
          if (s_axi_acready) begin
            acvalid_q  <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= werr_q ? RESP_SLVERR : RESP_OKAY;
            wr_state_q <= W_RESP;
          end
        end
`endif
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

`ifdef AXI_MEM_SNOOP_INV_EN
  assign s_axi_acvalid = acvalid_q;
  assign s_axi_acaddr  = acaddr_q;
  assign s_axi_acsnoop = acvalid_q ? SNOOP_MAKE_INVALID : 4'h0;
`else
  assign s_axi_acvalid = 1'b0;
  assign s_axi_acaddr  = '0;
  assign s_axi_acsnoop = 4'h0;
`endif

  // --------------------------------------------------------------------------
  // Read path state
  // --------------------------------------------------------------------------
  rd_state_e             rd_state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] raddr_d;
  logic [7:0]            rlen_q;
  logic [1:0]            rburst_q;
  logic [7:0]            rcnt_q;
  logic [7:0]            rwait_q;

  logic [ADDR_WIDTH-1:0] w_rbeat_addr;
  logic                  w_rbeat_oob;
  logic [DATA_WIDTH-1:0] w_rbeat_data;
  logic [1:0]            w_rbeat_resp;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_addr (
    .addr_i      (raddr_q),
    .len_i       (rlen_q),
    .burst_i     (rburst_q),
    .next_addr_o (raddr_d)
  );

  // First beat comes from the latched start address; later beats from the
  // stepped address. The RAM read sees pre-write contents on a same-edge write.
  assign w_rbeat_addr = (rd_state_q == R_DATA) ? raddr_d : raddr_q;
  assign w_rbeat_oob  = w_rbeat_addr[ADDR_WIDTH-1:3] >= c_mem_words;
  assign w_rbeat_data = w_rbeat_oob ? '0 : mem_q[w_rbeat_addr[3 +: c_idx_w]];
  assign w_rbeat_resp = (w_rbeat_oob || (rburst_q == RSVD)) ? RESP_SLVERR : RESP_OKAY;

  // Read FSM: accept AR, wait out the latency, then stream beats under rready.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      raddr_q    <= '0;
      rlen_q     <= 8'd0;
      rburst_q   <= 2'b00;
      rcnt_q     <= 8'd0;
      rwait_q    <= 8'd0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            arready_q  <= 1'b0;
            rid_q      <= s_axi_arid;
            raddr_q    <= s_axi_araddr;
            rlen_q     <= s_axi_arlen;
            rburst_q   <= s_axi_arburst;
            rcnt_q     <= 8'd0;
            rwait_q    <= c_rd_wait;
            rd_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rwait_q == 8'd0) begin
            rvalid_q   <= 1'b1;
            rdata_q    <= w_rbeat_data;
            rresp_q    <= w_rbeat_resp;
            rlast_q    <= (rlen_q == 8'd0);
            rd_state_q <= R_DATA;
          end else begin
            rwait_q <= rwait_q - 8'd1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              raddr_q <= raddr_d;
              rcnt_q  <= rcnt_q + 8'd1;
              rdata_q <= w_rbeat_data;
              rresp_q <= w_rbeat_resp;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
            end
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

  // Sideband inputs that the model accepts but does not act on.
  logic w_unused;
`ifdef AXI_MEM_SNOOP_INV_EN
  assign w_unused = &{1'b0, s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                      s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                      s_axi_wlast};
`else
  assign w_unused = &{1'b0, s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                      s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                      s_axi_wlast, s_axi_acready};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_responder
//  Description : Directed self-checking bench for axi_mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_mem_responder;

  localparam int IDW       = 13;
  localparam int AW        = 64;
  localparam int DW        = 64;
  localparam int MEM_WORDS = 4096;
  localparam int RL        = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [IDW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr, s_axi_acaddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awlock, s_axi_arlock;
  logic [3:0]    s_axi_awcache, s_axi_arcache, s_axi_acsnoop;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready, s_axi_acvalid, s_axi_acready;

  int checks = 0;
  int errors = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [63:0] stall_data;
  int          last_lat;
  logic [1:0]  bresp_got;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_acvalid(s_axi_acvalid), .s_axi_acready(s_axi_acready),
    .s_axi_acaddr(s_axi_acaddr), .s_axi_acsnoop(s_axi_acsnoop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [12:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    chk("aw_ready", 64'(s_axi_awready), 64'd1);
    tick();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input int nbeats);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = (i == nbeats - 1);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      chk("w_ready", 64'(s_axi_wready), 64'd1);
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
  endtask

  task automatic get_b(input logic [12:0] id, input int delay);
    int n;
    s_axi_bready = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    chk("b_valid", 64'(s_axi_bvalid), 64'd1);
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("b_hold", 64'(s_axi_bvalid), 64'd1);
    end
    chk("b_id", 64'(s_axi_bid), 64'(id));
    bresp_got = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("b_drop", 64'(s_axi_bvalid), 64'd0);
  endtask

  task automatic do_write(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int bdelay);
    send_aw(id, addr, len, burst);
    send_w(int'(len) + 1);
    get_b(id, bdelay);
  endtask

  task automatic send_ar(input logic [12:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    chk("ar_ready", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_beat, input int stall_n);
    int n, b, lat;
    send_ar(id, addr, len, burst);
    s_axi_rready = 1'b1;
    lat = 0;
    while (!s_axi_rvalid && lat < 50) begin tick(); lat++; end
    last_lat = lat;
    b = 0;
    n = 0;
    while (b <= int'(len) && b < 16 && n < 200) begin
      if (b == stall_beat && s_axi_rvalid) begin
        s_axi_rready = 1'b0;
        stall_data = s_axi_rdata;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          chk("r_stall_valid", 64'(s_axi_rvalid), 64'd1);
        end
        s_axi_rready = 1'b1;
      end
      if (s_axi_rvalid) begin
        rd[b] = s_axi_rdata; rr[b] = s_axi_rresp; rl[b] = s_axi_rlast;
        chk("r_id", 64'(s_axi_rid), 64'(id));
        b++;
      end
      tick();
      n++;
    end
    s_axi_rready = 1'b0;
    chk("r_beat_count", 64'(b), 64'(len) + 64'd1);
    chk("r_done", 64'(s_axi_rvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
    s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
    s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; s_axi_acready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_wready",  64'(s_axi_wready),  64'd0);
    chk("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
    chk("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
    chk("rst_acvalid", 64'(s_axi_acvalid), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_awready", 64'(s_axi_awready), 64'd1);
    chk("post_rst_arready", 64'(s_axi_arready), 64'd1);

    // 1. INCR write then read back
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    do_write(13'h1ABC, 64'h100, 8'd3, 2'b01, 0);
    chk("t1_bresp", 64'(bresp_got), 64'd0);
    do_read(13'h0155, 64'h100, 8'd3, 2'b01, -1, 0);
    chk("t1_latency", 64'(last_lat), 64'(RL));
    chk("t1_rd0", rd[0], 64'h11);
    chk("t1_rd1", rd[1], 64'h22);
    chk("t1_rd2", rd[2], 64'h33);
    chk("t1_rd3", rd[3], 64'h44);
    chk("t1_rl", 64'({rl[0], rl[1], rl[2], rl[3]}), 64'b0001);
    chk("t1_rresp", 64'({rr[0], rr[3]}), 64'd0);

    // 2. WRAP read across the 32-byte window
    wd[0] = 64'h100; wd[1] = 64'h108; wd[2] = 64'h110; wd[3] = 64'h118;
    do_write(13'h0002, 64'h100, 8'd3, 2'b01, 0);
    chk("t2_bresp", 64'(bresp_got), 64'd0);
    do_read(13'h0003, 64'h118, 8'd3, 2'b10, -1, 0);
    chk("t2_rd0", rd[0], 64'h118);
    chk("t2_rd1", rd[1], 64'h100);
    chk("t2_rd2", rd[2], 64'h108);
    chk("t2_rd3", rd[3], 64'h110);

    // FIXED read repeats one word; reserved burst steps as INCR with SLVERR
    do_read(13'h0004, 64'h108, 8'd2, 2'b00, -1, 0);
    chk("fixed_rd0", rd[0], 64'h108);
    chk("fixed_rd2", rd[2], 64'h108);
    chk("fixed_rl",  64'({rl[0], rl[1], rl[2]}), 64'b001);
    do_read(13'h0005, 64'h100, 8'd1, 2'b11, -1, 0);
    chk("rsvd_rd1",  rd[1], 64'h108);
    chk("rsvd_resp", 64'({rr[0], rr[1]}), 64'b1010);

    // 3. Byte strobes
    wd[0] = '1; ws[0] = 8'hFF;
    do_write(13'h0006, 64'h200, 8'd0, 2'b01, 0);
    wd[0] = '0; ws[0] = 8'h0F;
    do_write(13'h0007, 64'h200, 8'd0, 2'b01, 0);
    do_read(13'h0008, 64'h200, 8'd0, 2'b01, -1, 0);
    chk("t3_strb", rd[0], 64'hFFFF_FFFF_0000_0000);

    // 4. Out-of-range accesses
    do_read(13'h0009, 64'(MEM_WORDS * 8), 8'd0, 2'b01, -1, 0);
    chk("t4_oob_rdata", rd[0], 64'd0);
    chk("t4_oob_rresp", 64'(rr[0]), 64'd2);
    wd[0] = 64'hAAAA; ws[0] = 8'hFF;
    do_write(13'h000A, 64'(MEM_WORDS * 8 - 8), 8'd0, 2'b01, 0);
    chk("t4_edge_bresp", 64'(bresp_got), 64'd0);
    wd[0] = 64'h5555;
    do_write(13'h000B, 64'(MEM_WORDS * 8), 8'd0, 2'b01, 0);
    chk("t4_oob_bresp", 64'(bresp_got), 64'd2);
    do_read(13'h000C, 64'(MEM_WORDS * 8 - 8), 8'd0, 2'b01, -1, 0);
    chk("t4_neighbour", rd[0], 64'hAAAA);
    wd[0] = 64'h77; wd[1] = 64'h88; ws[1] = 8'hFF;
    do_write(13'h000D, 64'(MEM_WORDS * 8 - 8), 8'd1, 2'b01, 0);
    chk("t4_straddle_bresp", 64'(bresp_got), 64'd2);
    do_read(13'h000E, 64'(MEM_WORDS * 8 - 8), 8'd1, 2'b01, -1, 0);
    chk("t4_straddle_rd0", rd[0], 64'h77);
    chk("t4_straddle_rd1", rd[1], 64'd0);
    chk("t4_straddle_rr",  64'({rr[0], rr[1]}), 64'b0010);

    // 5. Backpressure on R and B
    do_read(13'h000F, 64'h100, 8'd3, 2'b01, 1, 3);
    chk("t5_stall_data", stall_data, 64'h108);
    chk("t5_rd0", rd[0], 64'h100);
    chk("t5_rd1", rd[1], 64'h108);
    chk("t5_rd2", rd[2], 64'h110);
    chk("t5_rd3", rd[3], 64'h118);
    wd[0] = 64'hBEEF; ws[0] = 8'hFF;
    do_write(13'h0010, 64'h300, 8'd0, 2'b01, 5);
    chk("t5_bresp", 64'(bresp_got), 64'd0);

    // 6. Snoop channel
`ifdef AXI_MEM_SNOOP_INV_EN
    begin
      int n;
      s_axi_acready = 1'b0;
      wd[0] = 64'h1238; ws[0] = 8'hFF;
      send_aw(13'h0011, 64'h1238, 8'd0, 2'b01);
      send_w(1);
      n = 0;
      while (!s_axi_acvalid && n < 50) begin tick(); n++; end
      chk("t6_acvalid", 64'(s_axi_acvalid), 64'd1);
      chk("t6_acaddr",  s_axi_acaddr, 64'h1200);
      chk("t6_acsnoop", 64'(s_axi_acsnoop), 64'hD);
      chk("t6_no_b0",   64'(s_axi_bvalid), 64'd0);
      tick(); tick();
      chk("t6_no_b1",   64'(s_axi_bvalid), 64'd0);
      chk("t6_ac_hold", 64'(s_axi_acvalid), 64'd1);
      s_axi_acready = 1'b1;
      tick();
      chk("t6_ac_drop", 64'(s_axi_acvalid), 64'd0);
      get_b(13'h0011, 0);
      chk("t6_bresp", 64'(bresp_got), 64'd0);
    end
`else
    chk("t6_ac_tied_valid", 64'(s_axi_acvalid), 64'd0);
    chk("t6_ac_tied_addr",  s_axi_acaddr, 64'd0);
    chk("t6_ac_tied_snoop", 64'(s_axi_acsnoop), 64'd0);
`endif

    // Reset in the middle of a write burst and a read burst
    begin
      int n;
      wd[0] = 64'h99; ws[0] = 8'hFF;
      send_aw(13'h0012, 64'h400, 8'd3, 2'b01);
      send_w(1);
      send_ar(13'h0013, 64'h100, 8'd3, 2'b01);
      n = 0;
      while (!s_axi_rvalid && n < 50) begin tick(); n++; end
      chk("rst_mid_rvalid_pre", 64'(s_axi_rvalid), 64'd1);
      chk("rst_mid_wready_pre", 64'(s_axi_wready), 64'd1);
      reset = 1'b1;
      tick();
      chk("rst_mid_rvalid",  64'(s_axi_rvalid),  64'd0);
      chk("rst_mid_rlast",   64'(s_axi_rlast),   64'd0);
      chk("rst_mid_wready",  64'(s_axi_wready),  64'd0);
      chk("rst_mid_bvalid",  64'(s_axi_bvalid),  64'd0);
      chk("rst_mid_awready", 64'(s_axi_awready), 64'd0);
      chk("rst_mid_arready", 64'(s_axi_arready), 64'd0);
      reset = 1'b0;
      tick();
      chk("rst_mid_awready_up", 64'(s_axi_awready), 64'd1);
      chk("rst_mid_wready_low", 64'(s_axi_wready),  64'd0);
    end
    do_read(13'h0014, 64'h200, 8'd0, 2'b01, -1, 0);
    chk("rst_retained", rd[0], 64'hFFFF_FFFF_0000_0000);
    wd[0] = 64'h5; ws[0] = 8'hFF;
    do_write(13'h0015, 64'h408, 8'd0, 2'b01, 0);
    do_read(13'h0016, 64'h400, 8'd1, 2'b01, -1, 0);
    chk("post_rst_rd0", rd[0], 64'h99);
    chk("post_rst_rd1", rd[1], 64'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
